dead_time_inserter: RTL and testbench
=====================================

Name: dead_time_inserter

Overview:
- Downstream stage of the three-phase SPWM generator. Consumes the comparator outputs Va/Vb/Vc (uncomplemented) and produces six gate-drive signals, one high-side and one low-side per leg.
- Inserts a programmable dead time at every transition so that the two switches of a leg are never on together.
- Adds an enable input and a sticky fault shutdown.
- Sits between the modulator and the device pins.

Parameters:
- CNT_W, 8, width of the dead-time counter and of dt_cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  run enable; low forces all gates off
- fault  input  1  external fault, active-high, level-sensitive
- fault_clr  input  1  clears the latched fault, one-cycle pulse
- dt_cycles  input  CNT_W  dead time in clk cycles; 0 is treated as 1
- Va  input  1  phase A PWM reference from the modulator
- Vb  input  1  phase B PWM reference
- Vc  input  1  phase C PWM reference
- Ga_h  output  1  phase A high-side gate
- Ga_l  output  1  phase A low-side gate
- Gb_h  output  1  phase B high-side gate
- Gb_l  output  1  phase B low-side gate
- Gc_h  output  1  phase C high-side gate
- Gc_l  output  1  phase C low-side gate
- fault_latched  output  1  sticky fault flag

Behaviour:
- All outputs are registered. While rst is high: every gate is 0, fault_latched is 0, every leg is in IDLE, and every counter is 0.
- Per-leg FSM states: IDLE (both gates off), DEAD (both off, counting), HI (h=1, l=0), LO (h=0, l=1).
- IDLE -> DEAD when en=1 and fault_latched=0 and fault=0. On that transition the counter loads max(dt_cycles,1).
- HI -> DEAD when sampled V=0. The h gate drops at that same edge and the counter loads.
- LO -> DEAD when sampled V=1. Symmetric to HI -> DEAD.
- DEAD decrements the counter once per cycle.
  - If V changes while in DEAD, the counter reloads from the current dt_cycles.
  - When the counter is 1 and V is unchanged, the next edge enters HI if V=1, otherwise LO.
- Timing guarantee: an input edge sampled at edge k removes the outgoing gate at edge k. The incoming gate asserts at edge k+D, where D=max(dt_cycles,1), so both gates are off for exactly D cycles.
- dt_cycles is sampled only on counter load. Changing it mid-count does not affect the current dead interval.
- Shutdown: en=0 or fault=1 or fault_latched=1 forces every leg to IDLE at the next edge from any state, and all gates go to 0.
- fault=1 sets fault_latched at the next edge.
- fault_clr=1 with fault=0 clears fault_latched at the next edge. If fault_clr and fault are high together, fault wins and the flag stays set.
- Restart after shutdown always passes through DEAD, so there are at least D cycles off before any gate turns on.
- Invariant: Gx_h & Gx_l == 0 in every cycle, including across reset and shutdown.
- A pulse on V shorter than D is swallowed: the counter keeps reloading and the gate that was on stays off until V is stable for D cycles.
- Reset asserted mid-operation turns all gates off immediately (asynchronously).

Optional Feature:
- Macro: DEAD_TIME_SYNC_EN.
- When defined: Va/Vb/Vc, fault and fault_clr each pass through a two-flop synchronizer reset to 0. This adds 2 cycles to every stated latency; the dead-time width is unchanged.
- When undefined: inputs are used directly. They are assumed synchronous to clk, since the modulator runs on the same clock.

Decomposition:
- Shared package dead_time_pkg holds:
  - the leg state enum (IDLE, DEAD, HI, LO) with a 2-bit encoding;
  - constant DT_MIN=1.
- Sub-module dead_time_leg implements one leg's FSM and counter. It takes V, dt_cycles and a shutdown input, and drives the h/l outputs.
- The top module instantiates dead_time_leg three times and owns the fault latch and the optional synchronizers.

Test Plan:
- Reset/start: rst released with en=1, dt_cycles=4, Va=1 -> Ga_h/Ga_l stay 0 for 4 cycles, then Ga_h=1.
- Transition: Va 1->0 at edge k with dt_cycles=4 -> Ga_h=0 from edge k, Ga_l=1 from edge k+4. Repeat for the 0->1 direction.
- Zero and change: dt_cycles=0 -> exactly 1 dead cycle. Change dt_cycles from 4 to 10 mid-dead -> current interval stays 4 and the next transition uses 10.
- Glitch: Vb high for 2 cycles while in LO with dt_cycles=5 -> Gb_h never asserts, Gb_l drops, and the leg returns to LO after 5 stable cycles.
- Fault: fault pulsed for 1 cycle -> all gates 0 at the next edge and fault_latched=1. fault_clr together with fault -> flag stays set. fault_clr alone -> flag cleared, each leg passes through D dead cycles, then gates resume.
- Randomised Va/Vb/Vc with random dt_cycles for 10k cycles -> assertion that no h&l overlap ever occurs and that every off-to-on gap is at least D.

Source files
------------

// File: rtl/dead_time_pkg.sv
// Shared types and constants for the three-leg gate-drive dead-time inserter.
package dead_time_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } leg_state_t;

  localparam int DT_MIN = 1;

endpackage

// File: rtl/dead_time_leg.sv
// One inverter leg: complementary high/low gate drive with a programmable
// both-off interval at every switch-over; gates are registered from next state.
module dead_time_leg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v,
  input  logic             shutdown,
  input  logic [CNT_W-1:0] dt_cycles,
  output logic             h,
  output logic             l
);
  import dead_time_pkg::*;

  leg_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] dt_load;
  logic             v_q;

  assign dt_load = (dt_cycles < CNT_W'(DT_MIN)) ? CNT_W'(DT_MIN) : dt_cycles;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (shutdown) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = DEAD;
          cnt_n   = dt_load;
        end
        HI: if (!v) begin
          state_n = DEAD;
          cnt_n   = dt_load;
        end
        LO: if (v) begin
          state_n = DEAD;
          cnt_n   = dt_load;
        end
        DEAD: begin
          // Any movement of V restarts the interval, so short pulses are swallowed.
          if (v != v_q) begin
            cnt_n = dt_load;
          end else if (cnt == CNT_W'(1)) begin
            state_n = v ? HI : LO;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      v_q   <= 1'b0;
      h     <= 1'b0;
      l     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      v_q   <= v;
      h     <= (state_n == HI);
      l     <= (state_n == LO);
    end
  end

endmodule

// File: rtl/dead_time_inserter.sv
// Three-phase dead-time inserter with run enable and sticky fault shutdown.
// Optional DEAD_TIME_SYNC_EN adds two-flop synchronizers on V and fault inputs.
module dead_time_inserter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fault,
  input  logic             fault_clr,
  input  logic [CNT_W-1:0] dt_cycles,
  input  logic             Va,
  input  logic             Vb,
  input  logic             Vc,
  output logic             Ga_h,
  output logic             Ga_l,
  output logic             Gb_h,
  output logic             Gb_l,
  output logic             Gc_h,
  output logic             Gc_l,
  output logic             fault_latched
);
  import dead_time_pkg::*;

  logic [2:0] v_s;
  logic       fault_s;
  logic       clr_s;
  logic       shutdown;

`ifdef DEAD_TIME_SYNC_EN
  logic [4:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {fault_clr, fault, Vc, Vb, Va};
      sync2 <= sync1;
    end
  end

  assign {clr_s, fault_s, v_s} = sync2;
`else
  assign v_s     = {Vc, Vb, Va};
  assign fault_s = fault;
  assign clr_s   = fault_clr;
`endif

  // Fault dominates a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_latched <= 1'b0;
    else if (fault_s)
      fault_latched <= 1'b1;
    else if (clr_s)
      fault_latched <= 1'b0;
  end

  assign shutdown = ~en | fault_s | fault_latched;

  dead_time_leg #(.CNT_W(CNT_W)) u_leg_a (
    .clk(clk), .rst(rst), .v(v_s[0]), .shutdown(shutdown),
    .dt_cycles(dt_cycles), .h(Ga_h), .l(Ga_l)
  );

  dead_time_leg #(.CNT_W(CNT_W)) u_leg_b (
    .clk(clk), .rst(rst), .v(v_s[1]), .shutdown(shutdown),
    .dt_cycles(dt_cycles), .h(Gb_h), .l(Gb_l)
  );

  dead_time_leg #(.CNT_W(CNT_W)) u_leg_c (
    .clk(clk), .rst(rst), .v(v_s[2]), .shutdown(shutdown),
    .dt_cycles(dt_cycles), .h(Gc_h), .l(Gc_l)
  );

endmodule

// File: tb/tb_dead_time_inserter.sv
// Bench for dead_time_inserter: directed scenarios plus randomised phases,
// every cycle compared against a timestamp-based reference of the gate rules.
module tb_dead_time_inserter;
`ifdef DEAD_TIME_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] dt_cycles = 8'd4;
  logic       Va = 1'b0;
  logic       Vb = 1'b0;
  logic       Vc = 1'b0;
  logic       Ga_h, Ga_l, Gb_h, Gb_l, Gc_h, Gc_l, fault_latched;

  int n_chk = 0;
  int n_pass = 0;

  // Reference: side = -1 gates off, 0 low gate on, 1 high gate on.
  int   side [3];
  bit   run [3];
  int   deadline [3];
  int   dload [3];
  logic vprev [3];
  logic flat;
  int   t = 0;
  logic [4:0] hist [2];

  int  off_run [3];
  bit  prev_on [3];
  bit  saw_gbh, saw_gbl_low;

  dead_time_inserter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fault(fault), .fault_clr(fault_clr),
    .dt_cycles(dt_cycles), .Va(Va), .Vb(Vb), .Vc(Vc),
    .Ga_h(Ga_h), .Ga_l(Ga_l), .Gb_h(Gb_h), .Gb_l(Gb_l), .Gc_h(Gc_h), .Gc_l(Gc_l),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [5:0] gates();
    return {Gc_l, Gc_h, Gb_l, Gb_h, Ga_l, Ga_h};
  endfunction

  task automatic model_step();
    logic [4:0] cur, eff;
    bit sd;
    int d;
    logic v;
    cur = {fault_clr, fault, Vc, Vb, Va};
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        side[i] = -1; run[i] = 0; deadline[i] = 0; dload[i] = 1; vprev[i] = 1'b0;
      end
      flat = 1'b0;
      hist[0] = '0;
      hist[1] = '0;
    end else begin
      if (LAT == 0) eff = cur;
      else eff = hist[1];
      hist[1] = hist[0];
      hist[0] = cur;
      sd = !en || eff[3] || flat;
      d = (dt_cycles == 8'd0) ? 1 : int'(dt_cycles);
      for (int i = 0; i < 3; i++) begin
        v = eff[i];
        if (sd) begin
          run[i] = 0; side[i] = -1;
        end else if (!run[i]) begin
          run[i] = 1; side[i] = -1; deadline[i] = t + d; dload[i] = d;
        end else if (side[i] >= 0) begin
          if (int'(v) != side[i]) begin
            side[i] = -1; deadline[i] = t + d; dload[i] = d;
          end
        end else if (v != vprev[i]) begin
          deadline[i] = t + d; dload[i] = d;
        end else if (t == deadline[i]) begin
          side[i] = int'(v);
        end
        vprev[i] = v;
      end
      flat = eff[3] ? 1'b1 : (eff[4] ? 1'b0 : flat);
    end
    t++;
  endtask

  task automatic cycle();
    logic [5:0] gv;
    @(posedge clk);
    model_step();
    #1;
    gv = gates();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("gate_h%0d", i), int'(gv[2*i]),   int'(side[i] == 1));
      check($sformatf("gate_l%0d", i), int'(gv[2*i+1]), int'(side[i] == 0));
      check($sformatf("overlap%0d", i), int'(gv[2*i] & gv[2*i+1]), 0);
      if (gv[2*i] | gv[2*i+1]) begin
        if (!prev_on[i]) check($sformatf("gap%0d_ge_D", i), int'(off_run[i] >= dload[i]), 1);
        off_run[i] = 0;
        prev_on[i] = 1;
      end else begin
        off_run[i]++;
        prev_on[i] = 0;
      end
    end
    check("fault_latched", int'(fault_latched), int'(flat));
    if (gv[2]) saw_gbh = 1;
    if (!gv[3]) saw_gbl_low = 1;
  endtask

  // Edges until gate `sel` rises (first edge counts as 1); -1 on timeout.
  task automatic wait_rise(input int sel, input int bound, output int n);
    logic [5:0] gv;
    logic prev;
    gv = gates();
    prev = gv[sel];
    n = 0;
    for (int k = 0; k < bound; k++) begin
      cycle();
      n++;
      gv = gates();
      if (gv[sel] && !prev) return;
      prev = gv[sel];
    end
    n = -1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin off_run[i] = 0; prev_on[i] = 0; end

    rst = 1'b1; en = 1'b1; dt_cycles = 8'd4; Va = 1'b1;
    repeat (3) cycle();
    check("rst_gates", int'(gates()), 0);
    check("rst_flag", int'(fault_latched), 0);

    rst = 1'b0;
    wait_rise(0, 40, n);
    check("start_lat", n, 5 + LAT);

    Va = 1'b0;
    repeat (1 + LAT) cycle();
    check("h_drop_same_edge", int'(Ga_h), 0);
    wait_rise(1, 40, n);
    check("fall_dt4", n, 4);

    Va = 1'b1;
    repeat (1 + LAT) cycle();
    check("l_drop_same_edge", int'(Ga_l), 0);
    wait_rise(0, 40, n);
    check("rise_dt4", n, 4);

    dt_cycles = 8'd0; Va = 1'b0;
    repeat (1 + LAT) cycle();
    wait_rise(1, 40, n);
    check("dt0_one_cycle", n, 1);

    dt_cycles = 8'd4; Va = 1'b1;
    repeat (1 + LAT) cycle();
    dt_cycles = 8'd10;
    wait_rise(0, 40, n);
    check("dt_change_mid_dead", n, 4);

    Va = 1'b0;
    repeat (1 + LAT) cycle();
    wait_rise(1, 40, n);
    check("dt_next_uses_10", n, 10);

    dt_cycles = 8'd5;
    check("glitch_pre_lo", int'(Gb_l), 1);
    saw_gbh = 0; saw_gbl_low = 0;
    Vb = 1'b1;
    repeat (2) cycle();
    Vb = 1'b0;
    wait_rise(3, 40, n);
    check("glitch_relo", n, 6 + LAT);
    check("glitch_no_h", int'(saw_gbh), 0);
    check("glitch_l_dropped", int'(saw_gbl_low), 1);

    dt_cycles = 8'd3;
    fault = 1'b1;
    cycle();
    fault = 1'b0;
    repeat (LAT) cycle();
    check("fault_gates_off", int'(gates()), 0);
    check("fault_set", int'(fault_latched), 1);

    fault = 1'b1; fault_clr = 1'b1;
    cycle();
    fault = 1'b0; fault_clr = 1'b0;
    repeat (LAT + 2) cycle();
    check("fault_wins_clr", int'(fault_latched), 1);

    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    repeat (LAT) cycle();
    check("fault_cleared", int'(fault_latched), 0);
    wait_rise(1, 40, n);
    check("restart_dead", n, 4);

    en = 1'b0;
    cycle();
    check("en_low_off", int'(gates()), 0);
    en = 1'b1;

    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(15) == 0) Va = ~Va;
      if ($urandom_range(15) == 0) Vb = ~Vb;
      if ($urandom_range(15) == 0) Vc = ~Vc;
      if ($urandom_range(199) == 0) dt_cycles = 8'($urandom_range(12));
      fault     = ($urandom_range(999) == 0);
      fault_clr = ($urandom_range(49) == 0);
      en        = ($urandom_range(1999) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
